// File: rtl/flit_injector.sv
// Packet-to-flit injector for one NoC input port.
// Emits header, body and tail flits under arbiter grant with retry accounting.
module flit_injector #(
    parameter int DATA_W     = 32,
    parameter int WAIT_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [11:0]       pkt_length,
    input  logic [3:0]        pkt_dest,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic [DATA_W-1:0] flit_data,
    output logic              flit_valid,
    output logic              busy,
    output logic              err_wait,
    output logic [7:0]        retry_cnt
);

    localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0] WLIM = WW'(WAIT_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, BODY, TAIL} state_t;

    state_t        state;
    state_t        next;
    logic [11:0]   len_q;
    logic [11:0]   body_q;
    logic [3:0]    dest_q;
    logic [WW-1:0] wait_cnt;
    logic          grant_q;
    logic          accept;
    logic          xfer;
    logic [11:0]   eff_len;

    assign accept  = pkt_valid && pkt_ready;
    assign xfer    = grant && flit_valid;
    assign eff_len = (pkt_length < 12'd2) ? 12'd2 : pkt_length;
    assign busy    = (state != IDLE);
    assign length  = len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (accept) next = REQ;
            REQ: begin
                if (grant) next = (body_q != 12'd0) ? BODY : TAIL;
            end
            BODY: if (xfer && body_q == 12'd1) next = TAIL;
            TAIL: if (xfer) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        pkt_ready  = 1'b0;
        req        = 1'b0;
        flit_id    = 3'b000;
        flit_valid = 1'b0;
        flit_data  = '0;
        data_ready = 1'b0;
        unique case (state)
            // rst gating keeps pkt_ready low while reset is held
            IDLE: pkt_ready = rst;
            REQ: begin
                req        = 1'b1;
                flit_id    = 3'b001;
                flit_valid = 1'b1;
                flit_data  = DATA_W'({dest_q, len_q});
            end
            BODY: begin
                req        = 1'b1;
                flit_valid = data_valid;
                flit_id    = data_valid ? 3'b010 : 3'b000;
                flit_data  = data_in;
                data_ready = grant;
            end
            TAIL: begin
                req        = 1'b1;
                flit_valid = data_valid;
                flit_id    = data_valid ? 3'b100 : 3'b000;
                flit_data  = data_in;
                data_ready = grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q     <= '0;
            body_q    <= '0;
            dest_q    <= '0;
            wait_cnt  <= '0;
            grant_q   <= 1'b0;
            err_wait  <= 1'b0;
            retry_cnt <= '0;
        end else begin
            grant_q <= grant;
            if (accept) begin
                len_q  <= eff_len;
                dest_q <= pkt_dest;
                body_q <= eff_len - 12'd2;
            end else if (state == BODY && xfer) begin
                body_q <= body_q - 12'd1;
            end else if (state == TAIL && xfer) begin
                len_q <= '0;
            end
            if (state == REQ && !grant) begin
                if (wait_cnt != WLIM) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt == WLIM - 1'b1) err_wait <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            // a falling grant mid-packet is a lost slot
            if ((state == BODY || state == TAIL) && grant_q && !grant
                && retry_cnt != 8'hFF) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
        end
    end

endmodule
